// File: rtl/poly1305_pkg.sv
// Shared types and byte-lane helpers for the Poly1305 block framer.
// Blocks are 16 bytes, byte 0 in bits [7:0].
package poly1305_pkg;

  localparam int BLK_BYTES = 16;
  localparam int DATA_W    = BLK_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AAD      = 3'd1,
    ST_PLD      = 3'd2,
    ST_LEN_EMIT = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  function automatic logic [4:0] keep_popcount(input logic [BLK_BYTES-1:0] keep);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < BLK_BYTES; i++) begin
      cnt = cnt + {4'b0000, keep[i]};
    end
    return cnt;
  endfunction

  // Contiguous from bit 0 means keep+1 is a power of two (or keep is 0).
  function automatic logic keep_is_contiguous(input logic [BLK_BYTES-1:0] keep);
    logic [BLK_BYTES:0] k;
    k = {1'b0, keep};
    return ((k + {{BLK_BYTES{1'b0}}, 1'b1}) & k) == '0;
  endfunction

  function automatic logic [DATA_W-1:0] mask_by_keep(input logic [DATA_W-1:0]    data,
                                                      input logic [BLK_BYTES-1:0] keep);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BLK_BYTES; i++) begin
      m[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/poly1305_pad_reg.sv
// Single-entry output register that zero-pads a beat to a full block and
// holds it, stable, until the downstream ready.
module poly1305_pad_reg
  import poly1305_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_fire,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [BLK_BYTES-1:0] in_keep,
  output logic                 free,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [BLK_BYTES-1:0] out_keep,
  input  logic                 out_ready
);

  logic                 vld_p1;
  logic [DATA_W-1:0]    data_p1;
  logic [BLK_BYTES-1:0] keep_p1;
  logic                 load_p0;

  // An all-zero keep ends the segment without producing a block.
  assign load_p0 = in_fire && (in_keep != '0);
  assign free    = !vld_p1 || out_ready;

  // p0 -> p1: accepted beat becomes the held block
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_p0) begin
      data_p1 <= mask_by_keep(in_data, in_keep);
      keep_p1 <= in_keep;
    end
  end

  // Data lanes are not reset, so they are gated to read as zero while empty.
  assign out_valid = vld_p1;
  assign out_data  = vld_p1 ? data_p1 : '0;
  assign out_keep  = vld_p1 ? keep_p1 : '0;

endmodule

// File: rtl/poly1305_block_framer.sv
// Frames AAD and payload byte streams into zero-padded 16-byte Poly1305
// blocks, counts segment lengths and emits the closing length block.
module poly1305_block_framer
  import poly1305_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,

  input  logic                 s_aad_valid,
  input  logic [DATA_W-1:0]    s_aad_data,
  input  logic [BLK_BYTES-1:0] s_aad_keep,
  input  logic                 s_aad_last,
  output logic                 s_aad_ready,

  input  logic                 s_pld_valid,
  input  logic [DATA_W-1:0]    s_pld_data,
  input  logic [BLK_BYTES-1:0] s_pld_keep,
  input  logic                 s_pld_last,
  output logic                 s_pld_ready,

  output logic                 aad_valid,
  output logic [DATA_W-1:0]    aad_data,
  output logic [BLK_BYTES-1:0] aad_keep,
  input  logic                 aad_ready,

  output logic                 pld_valid,
  output logic [DATA_W-1:0]    pld_data,
  output logic [BLK_BYTES-1:0] pld_keep,
  input  logic                 pld_ready,

  output logic                 len_valid,
  output logic [DATA_W-1:0]    len_block,
  input  logic                 len_ready,

  output logic [63:0]          aad_len,
  output logic [63:0]          pld_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err_keep
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] aad_cnt_q, pld_cnt_q;
  logic             done_q, err_keep_q;
  logic             aad_free, pld_free;
  logic             aad_fire, pld_fire, len_fire, start_ok;
  logic             aad_bad, pld_bad;

  function automatic logic keep_illegal(input logic [BLK_BYTES-1:0] keep, input logic last);
    return !keep_is_contiguous(keep)
        || (!last && (keep != {BLK_BYTES{1'b1}}))
        || ((keep == '0) && !last);
  endfunction

  assign s_aad_ready = (state_q == ST_AAD) && aad_free;
  assign s_pld_ready = (state_q == ST_PLD) && pld_free;
  assign aad_fire    = s_aad_valid && s_aad_ready;
  assign pld_fire    = s_pld_valid && s_pld_ready;
  assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Length block waits for both data paths to drain so it is always last.
  assign len_valid   = (state_q == ST_LEN_EMIT) && !pld_valid && !aad_valid;
  assign len_fire    = len_valid && len_ready;

  assign aad_bad     = aad_fire && keep_illegal(s_aad_keep, s_aad_last);
  assign pld_bad     = pld_fire && keep_illegal(s_pld_keep, s_pld_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_ok)                state_d = ST_AAD;
      ST_AAD:           if (aad_fire && s_aad_last)  state_d = ST_PLD;
      ST_PLD:           if (pld_fire && s_pld_last)  state_d = ST_LEN_EMIT;
      ST_LEN_EMIT:      if (len_fire)                state_d = ST_DONE;
      default:                                       state_d = ST_IDLE;
    endcase
  end

  // Byte counters wrap modulo 2^LEN_W.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      aad_cnt_q <= '0;
      pld_cnt_q <= '0;
    end else begin
      if (aad_fire) aad_cnt_q <= aad_cnt_q + LEN_W'(keep_popcount(s_aad_keep));
      if (pld_fire) pld_cnt_q <= pld_cnt_q + LEN_W'(keep_popcount(s_pld_keep));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= 1'b0;
      err_keep_q <= 1'b0;
    end else begin
      done_q     <= len_fire;
      err_keep_q <= aad_bad || pld_bad;
    end
  end

  poly1305_pad_reg u_aad_pad (
    .clk       (clk),
    .rst       (rst),
    .in_fire   (aad_fire),
    .in_data   (s_aad_data),
    .in_keep   (s_aad_keep),
    .free      (aad_free),
    .out_valid (aad_valid),
    .out_data  (aad_data),
    .out_keep  (aad_keep),
    .out_ready (aad_ready)
  );

  poly1305_pad_reg u_pld_pad (
    .clk       (clk),
    .rst       (rst),
    .in_fire   (pld_fire),
    .in_data   (s_pld_data),
    .in_keep   (s_pld_keep),
    .free      (pld_free),
    .out_valid (pld_valid),
    .out_data  (pld_data),
    .out_keep  (pld_keep),
    .out_ready (pld_ready)
  );

  assign aad_len   = 64'(aad_cnt_q);
  assign pld_len   = 64'(pld_cnt_q);
  assign len_block = {pld_len, aad_len};
  assign busy      = (state_q == ST_AAD) || (state_q == ST_PLD) || (state_q == ST_LEN_EMIT);
  assign done      = done_q;
  assign err_keep  = err_keep_q;

endmodule
